mdu_sequencer: RTL and testbench

- Sequences the multiply/divide unit and owns the HI/LO registers.
- Sits in EX. Driven by the decoder's `start`, `MDCCtrl`, `MDM_RE` and `MDM_WE` fields, plus EX-stage operands.
- Models fixed multi-cycle latency with a busy counter and commits results to HI/LO only at the end of the operation.
- Generates the decode-stage stall request for HI/LO-dependent instructions.

---
 rtl/mdu_sequencer.sv | 152 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multiply/divide sequencer owning HI/LO with fixed-latency busy counter
module mdu_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDCCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  MDM_WE,
  input  logic [1:0]  MDM_RE,
  input  logic        cancel,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   ph, pl;
  logic          pcommit;
  logic          accept, complete, wr_hi, wr_lo;
  logic          valid_op, is_div;
  logic [63:0]   result;
  logic          result_ok;

  logic [63:0]   sa, sb, ua, ub, sprod, uprod;
  logic [31:0]   sq, sr, uq, ur;

  assign valid_op = (MDCCtrl <= 3'b100);
  assign is_div   = (MDCCtrl == 3'b010) || (MDCCtrl == 3'b011);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign sa    = {{32{A[31]}}, A};
  assign sb    = {{32{B[31]}}, B};
  assign ua    = {32'b0, A};
  assign ub    = {32'b0, B};
  assign sprod = sa * sb;
  assign uprod = ua * ub;

  always_comb begin
    sq = 32'd0;
    sr = 32'd0;
    uq = 32'd0;
    ur = 32'd0;
    if (B != 32'd0) begin
      uq = A / B;
      ur = A % B;
      // Signed overflow case is pinned explicitly rather than left to the divider.
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        sq = 32'h8000_0000;
        sr = 32'd0;
      end else begin
        sq = $unsigned($signed(A) / $signed(B));
        sr = $unsigned($signed(A) % $signed(B));
      end
    end
  end

  always_comb begin
    result = 64'd0;
    case (MDCCtrl)
      3'b000:  result = sprod;
      3'b001:  result = uprod;
      3'b010:  result = {sr, sq};
      3'b011:  result = {ur, uq};
      3'b100:  result = {hi, lo} + sprod;
      default: result = 64'd0;
    endcase
  end

  assign result_ok = !(is_div && (B == 32'd0));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel && valid_op) begin
          accept     = 1'b1;
          cnt_next   = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
          state_next = BUSY;
        end else if (!start && !cancel) begin
          wr_hi = (MDM_WE == 2'b01);
          wr_lo = (MDM_WE == 2'b10);
        end
      end
      BUSY: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ph      <= 32'd0;
      pl      <= 32'd0;
      pcommit <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        {ph, pl} <= result;
        pcommit  <= result_ok;
      end
      if (complete) begin
        if (pcommit) begin
          hi <= ph;
          lo <= pl;
        end
      end else begin
        if (wr_hi) hi <= A;
        if (wr_lo) lo <= A;
      end
    end
  end

  assign busy  = (state == BUSY);
  assign stall = md_use_D & (busy | (start & ~cancel));

  always_comb begin
    case (MDM_RE)
      2'b01:   rdata = hi;
      2'b10:   rdata = lo;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDCCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  MDM_WE;
  logic [1:0]  MDM_RE;
  logic        cancel;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  mdu_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDCCtrl(MDCCtrl), .A(A), .B(B),
    .MDM_WE(MDM_WE), .MDM_RE(MDM_RE), .cancel(cancel), .md_use_D(md_use_D),
    .busy(busy), .stall(stall), .rdata(rdata), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic [1:0] we, input logic [31:0] val);
    MDM_WE = we;
    A = val;
    step();
    MDM_WE = 2'b00;
  endtask

  task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    MDCCtrl = ctrl;
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    md_use_D = 1'b1;
    MDM_RE = 2'b01;
    step();
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo got %h exp 0", lo); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b exp 0", stall); else pass_cnt++;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %h exp 0", rdata); else pass_cnt++;
    reset = 1'b1;
    md_use_D = 1'b0;
    MDM_RE = 2'b00;
    step();
  endtask

  task automatic test_mult();
    int cyc;
    issue(3'b000, 32'hFFFF_FFFE, 32'd3, cyc);
    total_cnt++; if (cyc !== 5) $display("FAIL mult_latency got %0d exp 5", cyc); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h exp fffffffa", lo); else pass_cnt++;
    MDM_RE = 2'b10;
    #1;
    total_cnt++; if (rdata !== 32'hFFFF_FFFA) $display("FAIL mult_rdata_lo got %h exp fffffffa", rdata); else pass_cnt++;
    MDM_RE = 2'b01;
    #1;
    total_cnt++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL mult_rdata_hi got %h exp ffffffff", rdata); else pass_cnt++;
    MDM_RE = 2'b00;
  endtask

  task automatic test_multu_stall();
    logic exp_s;
    MDCCtrl = 3'b001;
    A = 32'hFFFF_FFFF;
    B = 32'hFFFF_FFFF;
    start = 1'b1;
    md_use_D = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL stall_on_start got %0b exp 1", stall); else pass_cnt++;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      md_use_D = i[0];
      exp_s = i[0];
      #1;
      total_cnt++; if (busy !== 1'b1) $display("FAIL multu_busy_%0d got %0b exp 1", i, busy); else pass_cnt++;
      total_cnt++; if (stall !== exp_s) $display("FAIL multu_stall_%0d got %0b exp %0b", i, stall, exp_s); else pass_cnt++;
      step();
    end
    md_use_D = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL multu_done_busy got %0b exp 0", busy); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL multu_done_stall got %0b exp 0", stall); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h exp fffffffe", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo got %h exp 00000001", lo); else pass_cnt++;
    md_use_D = 1'b0;
  endtask

  task automatic test_div();
    int cyc;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, cyc);
    total_cnt++; if (cyc !== 10) $display("FAIL div_latency got %0d exp 10", cyc); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h exp fffffffd", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h exp ffffffff", hi); else pass_cnt++;
    issue(3'b011, 32'd100, 32'd7, cyc);
    total_cnt++; if (lo !== 32'd14) $display("FAIL divu_lo got %h exp 0000000e", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd2) $display("FAIL divu_hi got %h exp 00000002", hi); else pass_cnt++;
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    total_cnt++; if (lo !== 32'h8000_0000) $display("FAIL divovf_lo got %h exp 80000000", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL divovf_hi got %h exp 0", hi); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int cyc;
    mt(2'b01, 32'h11);
    mt(2'b10, 32'h22);
    issue(3'b011, 32'd1234, 32'd0, cyc);
    total_cnt++; if (cyc !== 10) $display("FAIL divz_latency got %0d exp 10", cyc); else pass_cnt++;
    total_cnt++; if (hi !== 32'h11) $display("FAIL divz_hi got %h exp 00000011", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h22) $display("FAIL divz_lo got %h exp 00000022", lo); else pass_cnt++;
  endtask

  task automatic test_madd();
    int cyc;
    mt(2'b01, 32'd0);
    mt(2'b10, 32'd5);
    issue(3'b100, 32'd3, 32'd4, cyc);
    total_cnt++; if (cyc !== 5) $display("FAIL madd_latency got %0d exp 5", cyc); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL madd_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd17) $display("FAIL madd_lo got %h exp 00000011", lo); else pass_cnt++;
    mt(2'b01, 32'hFFFF_FFFF);
    mt(2'b10, 32'hFFFF_FFFF);
    issue(3'b100, 32'd1, 32'd1, cyc);
    total_cnt++; if (hi !== 32'd0) $display("FAIL maddwrap_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd0) $display("FAIL maddwrap_lo got %h exp 0", lo); else pass_cnt++;
  endtask

  task automatic test_cancel();
    mt(2'b01, 32'hA5);
    mt(2'b10, 32'h5A);
    MDCCtrl = 3'b000;
    A = 32'd9;
    B = 32'd9;
    start = 1'b1;
    cancel = 1'b1;
    step();
    start = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL cancel_start_busy got %0b exp 0", busy); else pass_cnt++;
    MDM_WE = 2'b10;
    A = 32'h77;
    step();
    MDM_WE = 2'b00;
    cancel = 1'b0;
    total_cnt++; if (lo !== 32'h5A) $display("FAIL cancel_mtlo got %h exp 0000005a", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hA5) $display("FAIL cancel_hi got %h exp 000000a5", hi); else pass_cnt++;
    MDCCtrl = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reserved_busy got %0b exp 0", busy); else pass_cnt++;
    MDCCtrl = 3'b001;
    A = 32'd7;
    B = 32'd7;
    MDM_WE = 2'b10;
    start = 1'b1;
    step();
    start = 1'b0;
    MDM_WE = 2'b00;
    total_cnt++; if (lo !== 32'h5A) $display("FAIL start_prio_lo got %h exp 0000005a", lo); else pass_cnt++;
    while (busy) step();
    total_cnt++; if (lo !== 32'd49) $display("FAIL start_prio_result got %h exp 00000031", lo); else pass_cnt++;
  endtask

  task automatic test_start_in_busy();
    int cyc;
    MDCCtrl = 3'b000;
    A = 32'd2;
    B = 32'd3;
    start = 1'b1;
    step();
    MDCCtrl = 3'b010;
    A = 32'd100;
    B = 32'd7;
    cyc = 0;
    while (busy && cyc < 100) begin
      start = (cyc < 2);
      cyc++;
      step();
    end
    start = 1'b0;
    total_cnt++; if (cyc !== 5) $display("FAIL busy_start_latency got %0d exp 5", cyc); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL busy_start_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd6) $display("FAIL busy_start_lo got %h exp 00000006", lo); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mt(2'b01, 32'h55);
    MDCCtrl = 3'b011;
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy got %0b exp 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL midreset_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd0) $display("FAIL midreset_lo got %h exp 0", lo); else pass_cnt++;
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL postreset_busy got %0b exp 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL postreset_hi got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd0) $display("FAIL postreset_lo got %h exp 0", lo); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    MDCCtrl = 3'b000;
    A = 32'd0;
    B = 32'd0;
    MDM_WE = 2'b00;
    MDM_RE = 2'b00;
    cancel = 1'b0;
    md_use_D = 1'b0;
    test_reset();
    test_mult();
    test_multu_stall();
    test_div();
    test_div_zero();
    test_madd();
    test_cancel();
    test_start_in_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
